// File: rtl/nibble_mem_ctrl.sv
// nibble_mem_ctrl: command sequencer for the 64x4 nibble memory.
// Turns SEEK/WRITE/READ/RESYNC commands into next/prev/store strobe trains
// along the shortest wrap-around path, keeps a shadow of the memory address
// and reports one response per command, flagging any loss of address sync.
module nibble_mem_ctrl #(
  parameter int HOLD   = 2,  // cycles each strobe is high, then low (min 1)
  parameter int SETTLE = 4   // wait cycles before sampling memory outputs (min 4)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_addr,
  input  logic [3:0] cmd_data,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic [5:0] rsp_addr,
  output logic       sync_err,
  output logic [3:0] mem_din,
  output logic       mem_store,
  output logic       mem_next,
  output logic       mem_prev,
  input  logic [3:0] mem_dout,
  input  logic [5:0] mem_addr
);

  localparam logic [1:0] OP_SEEK   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_RESYNC = 2'b11;

  // One down-counter serves both the strobe phases and the settle wait.
  localparam int TMAX = (HOLD > SETTLE) ? HOLD : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_STEP_HI,
    S_STEP_LO,
    S_STORE_HI,
    S_STORE_LO,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [5:0]    addr_q;
  logic [5:0]    cur;        // shadow of the memory's address
  logic [5:0]    step_cnt;   // steps still to issue
  logic          dir_prev;   // 1: walking down with mem_prev
  logic [TW-1:0] timer;

  logic [5:0] diff;
  logic [5:0] plan_steps;
  logic       plan_prev;
  logic       is_write;

  // Shortest-path plan: forward distance, reversed when more than half-way.
  // NOTE: every variable here is assigned on every pass, so no latch is inferred.
  always_comb begin
    diff       = addr_q - cur;               // 6-bit wrap gives (addr - cur) mod 64
    plan_prev  = (diff > 6'd32);             // tie at 32 stays on mem_next
    plan_steps = plan_prev ? (6'd0 - diff) : diff;
    is_write   = (op_q == OP_WRITE);
  end

  // Sequencer: state, counters, shadow address and all registered outputs.
  // NOTE: state is updated with non-blocking assignments so every branch sees
  // the pre-edge values; the async reset also drops strobes mid-command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_SEEK;
      addr_q    <= '0;
      cur       <= '0;
      step_cnt  <= '0;
      dir_prev  <= 1'b0;
      timer     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      sync_err  <= 1'b0;
      mem_din   <= '0;
      mem_store <= 1'b0;
      mem_next  <= 1'b0;
      mem_prev  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            addr_q    <= cmd_addr;
            mem_din   <= (cmd_op == OP_WRITE) ? cmd_data : 4'd0;
            cmd_ready <= 1'b0;
            state     <= S_PLAN;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_PLAN: begin
          step_cnt <= plan_steps;
          dir_prev <= plan_prev;
          if (op_q == OP_RESYNC || (plan_steps == 6'd0 && !is_write)) begin
            timer <= SETTLE_LOAD;
            state <= S_SETTLE;
          end else if (plan_steps != 6'd0) begin
            mem_next <= !plan_prev;
            mem_prev <= plan_prev;
            timer    <= HOLD_LOAD;
            state    <= S_STEP_HI;
          end else begin
            mem_store <= 1'b1;
            timer     <= HOLD_LOAD;
            state     <= S_STORE_HI;
          end
        end

        S_STEP_HI: begin
          if (timer == '0) begin
            mem_next <= 1'b0;
            mem_prev <= 1'b0;
            cur      <= dir_prev ? (cur - 6'd1) : (cur + 6'd1);
            step_cnt <= step_cnt - 6'd1;
            timer    <= HOLD_LOAD;
            state    <= S_STEP_LO;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_STEP_LO: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else if (step_cnt != 6'd0) begin
            mem_next <= !dir_prev;
            mem_prev <= dir_prev;
            timer    <= HOLD_LOAD;
            state    <= S_STEP_HI;
          end else if (is_write) begin
            mem_store <= 1'b1;
            timer     <= HOLD_LOAD;
            state     <= S_STORE_HI;
          end else begin
            timer <= SETTLE_LOAD;
            state <= S_SETTLE;
          end
        end

        S_STORE_HI: begin
          if (timer == '0) begin
            mem_store <= 1'b0;
            cur       <= cur + 6'd1;     // memory post-increments on store
            timer     <= HOLD_LOAD;
            state     <= S_STORE_LO;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_STORE_LO: begin
          if (timer == '0) begin
            timer <= SETTLE_LOAD;
            state <= S_SETTLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_SETTLE: begin
          if (timer == '0) begin
            rsp_data  <= mem_dout;
            // The memory's own address is authoritative; the shadow follows it.
            rsp_addr  <= mem_addr;
            cur       <= mem_addr;
            if (op_q != OP_RESYNC && mem_addr != cur) begin
              sync_err <= 1'b1;
            end
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_RESP: begin
          mem_din   <= '0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_mem_ctrl.sv
// Self-checking bench for nibble_mem_ctrl with a behavioural nibble memory
// (2-flop strobe synchroniser, edge detect, registered readout).
module tb_nibble_mem_ctrl;

  localparam int HOLD   = 2;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [5:0] cmd_addr = '0;
  logic [3:0] cmd_data = '0;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic [5:0] rsp_addr;
  logic       sync_err;
  logic [3:0] mem_din;
  logic       mem_store, mem_next, mem_prev;
  logic [3:0] mem_dout;
  logic [5:0] mem_addr;
  logic       inj_next = 1'b0;

  always #5 clk = ~clk;

  nibble_mem_ctrl #(.HOLD(HOLD), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_addr (rsp_addr),
    .sync_err (sync_err),
    .mem_din  (mem_din),
    .mem_store(mem_store),
    .mem_next (mem_next),
    .mem_prev (mem_prev),
    .mem_dout (mem_dout),
    .mem_addr (mem_addr)
  );

  // Behavioural nibble memory sharing rst_n with the controller.
  logic [3:0] marr [64];
  logic [2:0] sn, sp, ss;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) marr[i] <= '0;
      sn <= '0; sp <= '0; ss <= '0;
      mem_addr <= '0;
      mem_dout <= '0;
    end else begin
      sn <= {sn[1:0], mem_next | inj_next};
      sp <= {sp[1:0], mem_prev};
      ss <= {ss[1:0], mem_store};
      if (sn[1] && !sn[2]) mem_addr <= mem_addr + 6'd1;
      else if (sp[1] && !sp[2]) mem_addr <= mem_addr - 6'd1;
      else if (ss[1] && !ss[2]) begin
        marr[mem_addr] <= mem_din;
        mem_addr <= mem_addr + 6'd1;
      end
      mem_dout <= marr[mem_addr];
    end
  end

  // Strobe monitor: rising-edge counts and protocol violations.
  bit pn, pp, ps;
  int tot_next, tot_prev, tot_store, overlap, idle_strobe;
  always @(negedge clk) begin
    pn <= mem_next; pp <= mem_prev; ps <= mem_store;
    if (mem_next && !pn) tot_next <= tot_next + 1;
    if (mem_prev && !pp) tot_prev <= tot_prev + 1;
    if (mem_store && !ps) tot_store <= tot_store + 1;
    if (int'(mem_next) + int'(mem_prev) + int'(mem_store) > 1) overlap <= overlap + 1;
    if ((cmd_ready || rsp_valid) && (mem_next || mem_prev || mem_store))
      idle_strobe <= idle_strobe + 1;
  end

  int n_vec, n_miss;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: true memory position and contents vs. shadow address.
  int m_cur, m_maddr, m_err;
  int m_mem [64];

  task automatic model_reset();
    m_cur = 0; m_maddr = 0; m_err = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = 0;
  endtask

  task automatic model_cmd(input int op, input int addr, input int data,
                           output int e_next, output int e_prev, output int e_store,
                           output int e_data, output int e_addr, output int e_lat,
                           output int e_err);
    int d, target;
    d = (addr - m_cur + 64) % 64;
    e_next = 0; e_prev = 0;
    if (op != 3) begin
      if (d >= 1 && d <= 32) e_next = d;
      else if (d > 32) e_prev = 64 - d;
    end
    e_store = (op == 1) ? 1 : 0;
    target  = (m_cur + e_next - e_prev + e_store + 64) % 64;
    m_maddr = (m_maddr + e_next - e_prev + 64) % 64;
    if (e_store == 1) begin
      m_mem[m_maddr] = data;
      m_maddr = (m_maddr + 1) % 64;
    end
    if (op != 3 && m_maddr != target) m_err = 1;
    m_cur  = m_maddr;
    e_addr = m_maddr;
    e_data = m_mem[m_maddr];
    e_err  = m_err;
    e_lat  = 1 + 2 * HOLD * (e_next + e_prev + e_store) + SETTLE;
  endtask

  // Issue one command and compare everything observable about it.
  // Latency is counted in cycles after the accept edge (cycle 0 follows E0).
  task automatic apply(input string tag, input int op, input int addr, input int data,
                       input int e_next, input int e_prev, input int e_store,
                       input int e_data, input int e_addr, input int e_lat, input int e_err);
    int w, lat, b_n, b_p, b_s;
    bit got;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".ready"}, int'(cmd_ready), 1);
    b_n = tot_next; b_p = tot_prev; b_s = tot_store;
    cmd_op = 2'(op); cmd_addr = 6'(addr); cmd_data = 4'(data); cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    got = 1'b0; lat = 0;
    while (!got && lat < 400) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      else lat++;
    end
    check({tag, ".rsp_seen"}, int'(got), 1);
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".rsp_data"}, int'(rsp_data), e_data);
    check({tag, ".rsp_addr"}, int'(rsp_addr), e_addr);
    check({tag, ".sync_err"}, int'(sync_err), e_err);
    check({tag, ".next_pulses"}, tot_next - b_n, e_next);
    check({tag, ".prev_pulses"}, tot_prev - b_p, e_prev);
    check({tag, ".store_pulses"}, tot_store - b_s, e_store);
    @(negedge clk);
    check({tag, ".rsp_one_cycle"}, int'(rsp_valid), 0);
    check({tag, ".ready_after"}, int'(cmd_ready), 1);
  endtask

  task automatic model_apply(input string tag, input int op, input int addr, input int data);
    int en, ep, es, ed, ea, el, ee;
    model_cmd(op, addr, data, en, ep, es, ed, ea, el, ee);
    apply(tag, op, addr, data, en, ep, es, ed, ea, el, ee);
  endtask

  typedef struct {
    int op, addr, data;
    int e_next, e_prev, e_store, e_data, e_addr, e_lat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int en, ep, es, ed, ea, el, ee, w, rsp_seen;

    // op, addr, data | next, prev, store, rsp_data, rsp_addr, latency
    tbl[0]  = '{2,  0,  0,   0, 0, 0,   0,  0,   5};  // READ 0 after reset
    tbl[1]  = '{1,  5, 10,   5, 0, 1,   0,  6,  29};  // WRITE 5 <- A
    tbl[2]  = '{2,  5,  0,   0, 1, 0,  10,  5,   9};  // READ 5
    tbl[3]  = '{0,  0,  0,   0, 5, 0,   0,  0,  25};  // SEEK 0
    tbl[4]  = '{0, 63,  0,   0, 1, 0,   0, 63,   9};  // SEEK 63 wraps backward
    tbl[5]  = '{0, 31,  0,  32, 0, 0,   0, 31, 133};  // tie at 32 -> next
    tbl[6]  = '{1, 63, 15,  32, 0, 1,   0,  0, 137};  // WRITE 63 leaves cur 0
    tbl[7]  = '{2, 63,  0,   0, 1, 0,  15, 63,   9};  // READ 63
    tbl[8]  = '{3,  0,  0,   0, 0, 0,  15, 63,   5};  // RESYNC, in sync
    tbl[9]  = '{1, 63,  3,   0, 0, 1,   0,  0,   9};  // WRITE with d==0
    tbl[10] = '{2, 62,  0,   0, 2, 0,   0, 62,  13};  // READ 62
    tbl[11] = '{2, 63,  0,   1, 0, 0,   3, 63,   9};  // READ 63

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs",
          int'({cmd_ready, rsp_valid, sync_err, mem_store, mem_next, mem_prev,
                mem_din, rsp_data, rsp_addr}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(cmd_ready), 1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      model_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, en, ep, es, ed, ea, el, ee);
      apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data,
            tbl[i].e_next, tbl[i].e_prev, tbl[i].e_store,
            tbl[i].e_data, tbl[i].e_addr, tbl[i].e_lat, 0);
    end

    // Loss of sync: an extra next pulse straight into the memory
    @(negedge clk);
    inj_next = 1'b1;
    repeat (3) @(negedge clk);
    inj_next = 1'b0;
    repeat (4) @(negedge clk);
    m_maddr = (m_maddr + 1) % 64;
    model_apply("inject_read", 2, m_cur, 0);
    check("inject.sync_err_set", int'(sync_err), 1);
    model_apply("inject_resync", 3, 17, 0);
    check("resync.sync_err_kept", int'(sync_err), 1);
    model_apply("post_resync_read", 2, m_cur, 0);

    // Reset clears the sticky error
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset2.sync_err", int'(sync_err), 0);
    rst_n = 1'b1;
    model_reset();

    // Reset in the middle of a 10-step seek
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 16) begin
      @(negedge clk);
      w++;
    end
    cmd_op = 2'b00; cmd_addr = 6'd10; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    w = 0;
    while (!(mem_next && tot_next >= 3) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("midop.reached_step_hi", int'(mem_next), 1);
    rst_n = 1'b0;
    #1;
    check("midop.strobes_dropped", int'({mem_next, mem_prev, mem_store}), 0);
    check("midop.no_rsp_in_reset", int'(rsp_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("midop.ready_after_release", int'(cmd_ready), 1);
    rsp_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("midop.abandoned_no_rsp", rsp_seen, 0);
    model_apply("midop.read0", 2, 0, 0);

    // Randomised commands against the reference model
    for (int i = 0; i < 40; i++) begin
      model_apply($sformatf("rnd%0d", i), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    check("strobe_overlap", overlap, 0);
    check("strobe_while_idle", idle_strobe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
